// File: rtl/switch_event_encoder_if.sv
// Event stream between the switch event encoder and its consumer.
// master drives valid/index/multi; slave returns ready.
interface switch_event_encoder_if #(
  parameter int IDX_W = 3
);
  logic             ev_valid;
  logic             ev_ready;
  logic [IDX_W-1:0] ev_index;
  logic             ev_multi;

  modport master (
    output ev_valid,
    output ev_index,
    output ev_multi,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_index,
    input  ev_multi,
    output ev_ready
  );
endinterface

// File: rtl/switch_event_encoder.sv
// Switch event encoder: synchronises and debounces the raw slide switches,
// turns each committed change into one indexed event and buffers events in
// a small FIFO popped with a valid/ready handshake.
// Optional macro SW_RISING_ONLY_EN: when defined, only 0->1 toggles produce
// events; when undefined, both directions do.
module switch_event_encoder #(
  parameter int NUM_SW          = 8,
  parameter int IDX_W           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SW-1:0]     sw,
  input  logic                  clear,
  switch_event_encoder_if.master ev,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // The cycle in which the candidate is captured already counts as its first
  // unchanged cycle, so DEBOUNCE only has to see DEBOUNCE_CYCLES-1 more. That
  // puts the push DEBOUNCE_CYCLES+3 edges after sw is first sampled.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    COMMIT
  } state_t;

  state_t state;
  state_t next_state;

  logic [NUM_SW-1:0] sync1;
  logic [NUM_SW-1:0] sync2;
  logic [NUM_SW-1:0] stable;
  logic [NUM_SW-1:0] candidate;
  logic [CNT_W-1:0]  cnt;

  logic load_cand;
  logic cnt_inc;
  logic do_commit;

  logic [NUM_SW-1:0] changed;
  logic              push;
  logic [IDX_W-1:0]  push_index;
  logic              push_multi;

  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [IDX_W-1:0]  idx_mem   [FIFO_DEPTH];
  logic              multi_mem [FIFO_DEPTH];
  logic              empty;
  logic              full;
  logic              pop;
  logic              write;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Debounce FSM next-state logic; a bounce back to the stable pattern wins.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sync2 != stable) begin
          next_state = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sync2 == stable) begin
          next_state = IDLE;
        end else if (sync2 != candidate) begin
          next_state = DEBOUNCE;
        end else if (cnt == CNT_LAST) begin
          next_state = COMMIT;
        end
      end
      COMMIT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Debounce FSM control outputs driving the candidate/counter/stable datapath.
  always_comb begin
    load_cand = 1'b0;
    cnt_inc   = 1'b0;
    do_commit = 1'b0;
    case (state)
      IDLE: begin
        load_cand = (sync2 != stable);
      end
      DEBOUNCE: begin
        if (sync2 == stable) begin
          load_cand = 1'b0;
        end else if (sync2 != candidate) begin
          load_cand = 1'b1;
        end else if (cnt != CNT_LAST) begin
          cnt_inc = 1'b1;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
      end
      default: begin
        do_commit = 1'b0;
      end
    endcase
  end

  // Candidate capture, stability counter and committed switch pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      candidate <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else begin
      if (load_cand) begin
        candidate <= sync2;
        cnt       <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (do_commit) begin
        stable <= candidate;
      end
    end
  end

`ifdef SW_RISING_ONLY_EN
  assign changed = candidate & ~stable;
`else
  assign changed = candidate ^ stable;
`endif

  assign push = do_commit && (changed != '0);

  // Event encoding: highest changed switch wins, multi flags more than one change.
  always_comb begin
    push_index = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (changed[i]) begin
        push_index = IDX_W'(i);
      end
    end
    push_multi = ((changed & (changed - 1'b1)) != '0);
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = !empty && ev.ev_ready;
  assign write = push && (!full || pop);

  // Event FIFO with sticky overflow; clear flushes it and beats a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        idx_mem[i]   <= '0;
        multi_mem[i] <= 1'b0;
      end
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (write) begin
        idx_mem[wr_ptr[PTR_W-1:0]]   <= push_index;
        multi_mem[wr_ptr[PTR_W-1:0]] <= push_multi;
        wr_ptr                       <= wr_ptr + 1'b1;
      end
      if (push && !write) begin
        overflow <= 1'b1;
      end
    end
  end

  assign ev.ev_valid = !empty;
  assign ev.ev_index = idx_mem[rd_ptr[PTR_W-1:0]];
  assign ev.ev_multi = multi_mem[rd_ptr[PTR_W-1:0]];

endmodule
